// File: rtl/id_stage_pipe_if.sv
// Bundle of every ID-stage signal except clock and reset.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready on the fetch side and out_valid/out_ready on the EX side.
//   slave  : the decode stage's view (drives in_ready, regs_addr*, out_*, stall_count)
//   master : the surrounding pipeline's view (drives inst, regfile data, EX/WB status, out_ready)
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [XLEN-1:0]   inst_addr;
    logic              flush;
    logic [REG_AW-1:0] regs_addr1;
    logic [REG_AW-1:0] regs_addr2;
    logic [XLEN-1:0]   regs_data1;
    logic [XLEN-1:0]   regs_data2;
    logic              ex_valid;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_operand1;
    logic [XLEN-1:0]   out_operand2;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_store_data;
    logic [XLEN-1:0]   out_inst_addr;
    logic              out_illegal;
    logic [CNT_W-1:0]  stall_count;

    modport slave (
        input  in_valid, inst, inst_addr, flush, regs_data1, regs_data2,
               ex_valid, ex_is_load, ex_rd, wb_wen, wb_rd, wb_data, out_ready,
        output in_ready, regs_addr1, regs_addr2, out_valid, out_opcode, out_funct3,
               out_funct7, out_rd, out_operand1, out_operand2, out_imm,
               out_store_data, out_inst_addr, out_illegal, stall_count
    );

    modport master (
        output in_valid, inst, inst_addr, flush, regs_data1, regs_data2,
               ex_valid, ex_is_load, ex_rd, wb_wen, wb_rd, wb_data, out_ready,
        input  in_ready, regs_addr1, regs_addr2, out_valid, out_opcode, out_funct3,
               out_funct7, out_rd, out_operand1, out_operand2, out_imm,
               out_store_data, out_inst_addr, out_illegal, stall_count
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decodes inst, reads the regfile, registers operands into ID/EX.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: holds ID/EX while out_ready=0; load-use hazard drops in_ready and inserts bubbles.
// Ports: clk, rst (synchronous, active-high), bus (id_stage_pipe_if.slave).
// Optional: define ID_FORWARD_EN to bypass writeback data onto rs1/rs2 reads.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   inst_addr;
        logic              illegal;
    } idex_t;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic              use_rs1, use_rs2;
    logic              hazard, in_ready_int;
    idex_t             dec, idex_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  stall_q;

    assign opcode = bus.inst[6:0];
    assign rs1    = REG_AW'(bus.inst[19:15]);
    assign rs2    = REG_AW'(bus.inst[24:20]);
    assign rd     = REG_AW'(bus.inst[11:7]);

    assign imm_i = XLEN'($signed(bus.inst[31:20]));
    assign imm_s = XLEN'($signed({bus.inst[31:25], bus.inst[11:7]}));
    assign imm_b = XLEN'($signed({bus.inst[31], bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({bus.inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0}));

`ifdef ID_FORWARD_EN
    // Writeback bypass covers a regfile that is read-before-write in the same cycle.
    logic fwd1, fwd2;
    assign fwd1 = bus.wb_wen && (bus.wb_rd != '0) && (bus.wb_rd == rs1);
    assign fwd2 = bus.wb_wen && (bus.wb_rd != '0) && (bus.wb_rd == rs2);
`else
    logic fwd1, fwd2;
    logic unused_wb;
    assign fwd1      = 1'b0;
    assign fwd2      = 1'b0;
    assign unused_wb = ^{bus.wb_wen, bus.wb_rd, bus.wb_data};
`endif

    // x0 reads as zero no matter what the regfile or bypass presents.
    always_comb begin
        rs1_val = fwd1 ? bus.wb_data : bus.regs_data1;
        rs2_val = fwd2 ? bus.wb_data : bus.regs_data2;
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    always_comb begin
        dec           = '0;
        dec.opcode    = opcode;
        dec.funct3    = bus.inst[14:12];
        dec.funct7    = bus.inst[31:25];
        dec.inst_addr = bus.inst_addr;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        unique case (opcode)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.rd = rd; dec.op1 = rs1_val; dec.op2 = rs2_val;
            end
            OP_JALR: begin
                use_rs1 = 1'b1;
                dec.rd = rd; dec.op1 = rs1_val; dec.op2 = bus.inst_addr;
            end
            OP_IMM, OP_LOAD: begin
                use_rs1 = 1'b1;
                dec.rd = rd; dec.op1 = rs1_val; dec.op2 = imm_i;
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.op1 = rs1_val; dec.op2 = imm_s; dec.store_data = rs2_val;
            end
            OP_LUI: begin
                dec.rd = rd; dec.op2 = imm_u;
            end
            OP_AUIPC: begin
                dec.rd = rd; dec.op1 = bus.inst_addr; dec.op2 = imm_u;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.op1 = rs1_val; dec.op2 = rs2_val; dec.imm = imm_b;
            end
            OP_JAL: begin
                dec.rd = rd; dec.op1 = bus.inst_addr; dec.op2 = imm_j;
            end
            OP_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
    end

    assign bus.regs_addr1 = use_rs1 ? rs1 : '0;
    assign bus.regs_addr2 = use_rs2 ? rs2 : '0;

    // Load in EX writing a register this inst reads: its data isn't available until after EX.
    assign hazard = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != '0) &&
                    ((use_rs1 && (bus.ex_rd == rs1)) || (use_rs2 && (bus.ex_rd == rs2)));

    // Gated by flush so upstream never sees a handshake on a cycle whose inst is discarded.
    assign in_ready_int = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = in_ready_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (bus.in_valid && in_ready_int) begin
            idex_q      <= dec;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready && bus.in_valid && hazard) begin
            out_valid_q <= 1'b0;
            if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_opcode     = idex_q.opcode;
    assign bus.out_funct3     = idex_q.funct3;
    assign bus.out_funct7     = idex_q.funct7;
    assign bus.out_rd         = idex_q.rd;
    assign bus.out_operand1   = idex_q.op1;
    assign bus.out_operand2   = idex_q.op2;
    assign bus.out_imm        = idex_q.imm;
    assign bus.out_store_data = idex_q.store_data;
    assign bus.out_inst_addr  = idex_q.inst_addr;
    assign bus.out_illegal    = idex_q.illegal;
    assign bus.stall_count    = stall_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed cases followed by randomized traffic against a reference model.
// Latency: model predicts ID/EX contents one cycle after each accepted instruction.
// Backpressure: upstream holds a stalled instruction; out_ready, flush, hazards and reset are randomized.
module tb_id_stage_pipe;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) tif ();
    id_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(tif));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic        m_valid = 1'b0, m_ill = 1'b0;
    logic [6:0]  m_opcode = '0, m_f7 = '0;
    logic [2:0]  m_f3 = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_op1 = '0, m_op2 = '0, m_imm = '0, m_sd = '0, m_pc = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic        stall_prev = 1'b0;

    typedef struct {
        bit          use1, use2, ill;
        logic [4:0]  rd;
        logic [31:0] op1, op2, imm, sd;
    } dec_t;

    function automatic dec_t ref_decode(logic [31:0] i, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2);
        dec_t d;
        logic [31:0] ii = {{20{i[31]}}, i[31:20]};
        logic [31:0] is = {{20{i[31]}}, i[31:25], i[11:7]};
        logic [31:0] ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        logic [31:0] iu = {i[31:12], 12'h000};
        logic [31:0] ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d = '{default: '0};
        case (i[6:0])
            7'h33: begin d.use1 = 1; d.use2 = 1; d.rd = i[11:7]; d.op1 = v1; d.op2 = v2; end
            7'h67: begin d.use1 = 1; d.rd = i[11:7]; d.op1 = v1; d.op2 = pc; end
            7'h13, 7'h03: begin d.use1 = 1; d.rd = i[11:7]; d.op1 = v1; d.op2 = ii; end
            7'h23: begin d.use1 = 1; d.use2 = 1; d.op1 = v1; d.op2 = is; d.sd = v2; end
            7'h37: begin d.rd = i[11:7]; d.op2 = iu; end
            7'h17: begin d.rd = i[11:7]; d.op1 = pc; d.op2 = iu; end
            7'h63: begin d.use1 = 1; d.use2 = 1; d.op1 = v1; d.op2 = v2; d.imm = ib; end
            7'h6F: begin d.rd = i[11:7]; d.op1 = pc; d.op2 = ij; end
            7'h73: ;
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] reg_value(logic [4:0] rs, logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
`ifdef ID_FORWARD_EN
        if (tif.wb_wen && tif.wb_rd == rs) return tif.wb_data;
`endif
        return rf;
    endfunction

    // One clock: check combinational outputs, advance the model, then check the ID/EX register.
    task automatic step();
        dec_t d;
        logic hz, rdy;
        logic [4:0] rs1, rs2;
        #1;
        rs1 = tif.inst[19:15];
        rs2 = tif.inst[24:20];
        d = ref_decode(tif.inst, tif.inst_addr, reg_value(rs1, tif.regs_data1), reg_value(rs2, tif.regs_data2));
        hz  = tif.ex_valid && tif.ex_is_load && tif.ex_rd != 0 &&
              ((d.use1 && tif.ex_rd == rs1) || (d.use2 && tif.ex_rd == rs2));
        rdy = !tif.flush && !hz && (!m_valid || tif.out_ready);
        check("in_ready",   64'(tif.in_ready),   64'(rdy));
        check("regs_addr1", 64'(tif.regs_addr1), 64'(d.use1 ? rs1 : 5'd0));
        check("regs_addr2", 64'(tif.regs_addr2), 64'(d.use2 ? rs2 : 5'd0));
        if (rst) begin
            m_valid = 0; m_opcode = 0; m_f3 = 0; m_f7 = 0; m_rd = 0; m_op1 = 0; m_op2 = 0;
            m_imm = 0; m_sd = 0; m_pc = 0; m_ill = 0; m_cnt = 0;
        end else if (tif.flush) begin
            m_valid = 0;
        end else if (tif.in_valid && rdy) begin
            m_valid = 1; m_opcode = tif.inst[6:0]; m_f3 = tif.inst[14:12]; m_f7 = tif.inst[31:25];
            m_rd = d.rd; m_op1 = d.op1; m_op2 = d.op2; m_imm = d.imm; m_sd = d.sd;
            m_pc = tif.inst_addr; m_ill = d.ill;
        end else if (tif.out_ready && tif.in_valid && hz) begin
            m_valid = 0;
            if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        end else if (tif.out_ready) begin
            m_valid = 0;
        end
        stall_prev = tif.in_valid && !rdy;
        @(posedge clk);
        #1;
        check("out_valid",   64'(tif.out_valid),      64'(m_valid));
        check("out_opcode",  64'(tif.out_opcode),     64'(m_opcode));
        check("out_funct3",  64'(tif.out_funct3),     64'(m_f3));
        check("out_funct7",  64'(tif.out_funct7),     64'(m_f7));
        check("out_rd",      64'(tif.out_rd),         64'(m_rd));
        check("out_op1",     64'(tif.out_operand1),   64'(m_op1));
        check("out_op2",     64'(tif.out_operand2),   64'(m_op2));
        check("out_imm",     64'(tif.out_imm),        64'(m_imm));
        check("out_sdata",   64'(tif.out_store_data), 64'(m_sd));
        check("out_pc",      64'(tif.out_inst_addr),  64'(m_pc));
        check("out_illegal", 64'(tif.out_illegal),    64'(m_ill));
        check("stall_count", 64'(tif.stall_count),    64'(m_cnt));
    endtask

    task automatic drive_random();
        logic [31:0] r;
        logic [6:0]  op;
        rst            = ($urandom_range(0, 199) == 0);
        tif.flush      = ($urandom_range(0, 19) == 0);
        tif.out_ready  = ($urandom_range(0, 9) < 7);
        if (!stall_prev) begin
            case ($urandom_range(0, 11))
                0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
                4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
                8: op = 7'h17;  9: op = 7'h73;  10: op = 7'h7F; default: op = 7'h0B;
            endcase
            r             = $urandom();
            tif.inst      = {r[31:7], op};
            tif.inst_addr = $urandom() & 32'hFFFF_FFFC;
            tif.in_valid  = ($urandom_range(0, 9) < 8);
        end
        tif.ex_valid   = $urandom_range(0, 1);
        tif.ex_is_load = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
            0: tif.ex_rd = tif.inst[19:15];
            1: tif.ex_rd = tif.inst[24:20];
            2: tif.ex_rd = 5'd0;
            default: tif.ex_rd = 5'($urandom());
        endcase
        tif.regs_data1 = $urandom();
        tif.regs_data2 = $urandom();
        tif.wb_wen     = $urandom_range(0, 1);
        tif.wb_rd      = $urandom_range(0, 1) ? tif.inst[19:15] : 5'($urandom());
        tif.wb_data    = $urandom();
    endtask

    initial begin
        rst = 1'b1;
        tif.in_valid = 0; tif.inst = 32'd0; tif.inst_addr = 32'd0; tif.flush = 0;
        tif.regs_data1 = 32'd0; tif.regs_data2 = 32'd0;
        tif.ex_valid = 0; tif.ex_is_load = 0; tif.ex_rd = 5'd0;
        tif.wb_wen = 0; tif.wb_rd = 5'd0; tif.wb_data = 32'd0; tif.out_ready = 0;
        @(posedge clk);
        #1;
        step();
        check("rst_valid", 64'(tif.out_valid), 64'd0);
        check("rst_cnt",   64'(tif.stall_count), 64'd0);
        rst = 1'b0;

        // ADDI x1,x0,-5
        tif.inst = 32'hFFB0_0093; tif.in_valid = 1; tif.out_ready = 1; tif.regs_data1 = 32'h1234;
        step();
        check("addi_valid", 64'(tif.out_valid), 64'd1);
        check("addi_op1",   64'(tif.out_operand1), 64'd0);
        check("addi_op2",   64'(tif.out_operand2), 64'hFFFF_FFFB);
        check("addi_rd",    64'(tif.out_rd), 64'd1);

        // LUI x2,0x12345 then AUIPC x2,0x12345, both at PC 0x100
        tif.inst = 32'h1234_5137; tif.inst_addr = 32'h100;
        step();
        check("lui_op1", 64'(tif.out_operand1), 64'd0);
        check("lui_op2", 64'(tif.out_operand2), 64'h1234_5000);
        tif.inst = 32'h1234_5117;
        step();
        check("auipc_op1", 64'(tif.out_operand1), 64'h100);
        check("auipc_op2", 64'(tif.out_operand2), 64'h1234_5000);

        // ADD x4,x3,x5 behind a load to x3: one bubble, then issue
        tif.inst = 32'h0051_8233; tif.inst_addr = 32'h104;
        tif.regs_data1 = 32'h11; tif.regs_data2 = 32'h22;
        tif.ex_valid = 1; tif.ex_is_load = 1; tif.ex_rd = 5'd3;
        #1 check("hz_in_ready", 64'(tif.in_ready), 64'd0);
        step();
        check("hz_bubble", 64'(tif.out_valid), 64'd0);
        check("hz_count",  64'(tif.stall_count), 64'd1);
        tif.ex_valid = 0; tif.ex_is_load = 0; tif.ex_rd = 5'd0;
        step();
        check("hz_issue_valid", 64'(tif.out_valid), 64'd1);
        check("hz_issue_op1",   64'(tif.out_operand1), 64'h11);
        check("hz_issue_rd",    64'(tif.out_rd), 64'd4);

        // EX stalls for 3 cycles with a new inst waiting, then flush
        tif.inst = 32'hFFB0_0093; tif.out_ready = 0;
        repeat (3) step();
        check("hold_valid", 64'(tif.out_valid), 64'd1);
        check("hold_rd",    64'(tif.out_rd), 64'd4);
        tif.flush = 1;
        step();
        check("flush_valid", 64'(tif.out_valid), 64'd0);
        tif.flush = 0; tif.out_ready = 1;

        // ADD x6,x5,x0 with writeback of x5 in flight
        tif.inst = 32'h0002_8333; tif.regs_data1 = 32'd0; tif.regs_data2 = 32'h55;
        tif.wb_wen = 1; tif.wb_rd = 5'd5; tif.wb_data = 32'hDEAD;
        step();
`ifdef ID_FORWARD_EN
        check("fwd_op1", 64'(tif.out_operand1), 64'hDEAD);
`else
        check("nofwd_op1", 64'(tif.out_operand1), 64'd0);
`endif
        check("x0_op2", 64'(tif.out_operand2), 64'd0);
        tif.wb_wen = 0;

        // Unknown opcode
        tif.inst = 32'h0000_0FFF;
        step();
        check("illegal_flag", 64'(tif.out_illegal), 64'd1);
        check("illegal_rd",   64'(tif.out_rd), 64'd0);

        // Counter saturation under a long load-use stall
        tif.inst = 32'h0051_8233; tif.ex_valid = 1; tif.ex_is_load = 1; tif.ex_rd = 5'd5;
        repeat (20) step();
        check("sat_count", 64'(tif.stall_count), 64'(CNT_MAX));

        // Reset mid-stall beats flush and clears the counter
        rst = 1; tif.flush = 1;
        step();
        check("rst_stall_cnt",   64'(tif.stall_count), 64'd0);
        check("rst_stall_valid", 64'(tif.out_valid), 64'd0);
        rst = 0; tif.flush = 0; tif.ex_valid = 0;

        for (int k = 0; k < 3000; k++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
